// File: rtl/stim_pkg.sv
// Shared definitions for the stimulus sequencer: FSM encoding, step-word field
// offsets and the released-key level.
package stim_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_DONE = 2'd2
    } stim_state_t;

    // Step word is {last, delay, key, sw}; sw occupies the LSBs.
    localparam int SW_LSB = 0;

    function automatic int key_lsb(input int sw_w);
        return sw_w;
    endfunction

    function automatic int dly_lsb(input int sw_w, input int num_keys);
        return sw_w + num_keys;
    endfunction

    function automatic int last_pos(input int sw_w, input int num_keys, input int dly_w);
        return sw_w + num_keys + dly_w;
    endfunction

    function automatic int word_w(input int sw_w, input int num_keys, input int dly_w);
        return 1 + sw_w + num_keys + dly_w;
    endfunction

    // Keys are active-low, so a released key reads as one.
    localparam logic KEY_IDLE_BIT = 1'b1;

endpackage

// File: rtl/stim_step_mem.sv
// Step program store: DEPTH x WORD_W register file, synchronous write and
// combinational read. Contents are deliberately not reset.
module stim_step_mem #(
    parameter int DEPTH  = 16,
    parameter int WORD_W = 29
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WORD_W-1:0]        wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WORD_W-1:0]        rd_data
);

    logic [WORD_W-1:0] mem_r [DEPTH];

    // Program write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/stim_sequencer.sv
// Programmable KEY/SW stimulus player with loop, abort and start/busy/done.
// Optional trace ports step_idx/steps_applied exist when STIM_SEQ_TRACE_EN is defined.
module stim_sequencer
    import stim_pkg::*;
#(
    parameter int NUM_KEYS = 4,
    parameter int SW_W     = 8,
    parameter int DEPTH    = 16,
    parameter int DLY_W    = 16
) (
    input  logic                             CLOCK_50,
    input  logic                             Resetn,
    input  logic                             wr_en,
    input  logic [$clog2(DEPTH)-1:0]         wr_addr,
    input  logic [DLY_W+NUM_KEYS+SW_W:0]     wr_data,
    input  logic                             start,
    input  logic                             abort,
    input  logic                             loop_en,
    output logic [NUM_KEYS-1:0]              KEY_out,
    output logic [SW_W-1:0]                  SW_out,
    output logic                             busy,
    output logic                             done,
    output logic                             wr_err
`ifdef STIM_SEQ_TRACE_EN
    ,
    output logic [$clog2(DEPTH)-1:0]         step_idx,
    output logic [15:0]                      steps_applied
`endif
);

    localparam int AW      = $clog2(DEPTH);
    localparam int WORD_W  = word_w(SW_W, NUM_KEYS, DLY_W);
    localparam int KEY_LSB = key_lsb(SW_W);
    localparam int DLY_LSB = dly_lsb(SW_W, NUM_KEYS);
    localparam int LAST_B  = last_pos(SW_W, NUM_KEYS, DLY_W);

    stim_state_t         state_r, state_nxt;
    logic [AW-1:0]       ptr_r, ptr_nxt, rd_addr_s;
    logic [DLY_W-1:0]    cnt_r, cnt_nxt;
    logic [NUM_KEYS-1:0] key_r, key_nxt;
    logic [SW_W-1:0]     sw_r, sw_nxt;
    logic                busy_r, busy_nxt;
    logic                done_r, done_nxt;
    logic                last_r, last_nxt;
    logic                wr_err_r;
    logic                load_s, idle_s, expire_s, final_s, mem_we_s;
    logic [WORD_W-1:0]   rd_data_s;
    logic [DLY_W-1:0]    ld_dly_s, ld_cnt_s;

    assign mem_we_s = wr_en & (state_r != ST_PLAY);

    stim_step_mem #(
        .DEPTH  (DEPTH),
        .WORD_W (WORD_W)
    ) u_mem (
        .clk     (CLOCK_50),
        .we      (mem_we_s),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr_s),
        .rd_data (rd_data_s)
    );

    // The current step's last bit is captured at load time so the read port
    // only ever has to look up the step about to be applied.
    assign expire_s = (cnt_r <= DLY_W'(1));
    assign final_s  = last_r | (ptr_r == AW'(DEPTH - 1));
    assign ld_dly_s = rd_data_s[DLY_LSB +: DLY_W];
    assign ld_cnt_s = (ld_dly_s == {DLY_W{1'b0}}) ? DLY_W'(1) : ld_dly_s;

    // Address of the next step to load: successor while playing, else step 0
    always_comb begin
        rd_addr_s = {AW{1'b0}};
        if ((state_r == ST_PLAY) && expire_s && !final_s) begin
            rd_addr_s = ptr_r + AW'(1);
        end else begin
            rd_addr_s = {AW{1'b0}};
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt = state_r;
        ptr_nxt   = ptr_r;
        cnt_nxt   = cnt_r;
        key_nxt   = key_r;
        sw_nxt    = sw_r;
        last_nxt  = last_r;
        load_s    = 1'b0;
        idle_s    = 1'b0;

        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                    idle_s    = 1'b1;
                end else if (start) begin
                    state_nxt = ST_PLAY;
                    load_s    = 1'b1;
                end else begin
                    state_nxt = state_r;
                end
            end
            ST_PLAY: begin
                if (abort) begin
                    state_nxt = ST_IDLE;
                    idle_s    = 1'b1;
                end else if (expire_s) begin
                    if (final_s && !loop_en) begin
                        state_nxt = ST_DONE;
                    end else begin
                        load_s    = 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt_r - DLY_W'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                idle_s    = 1'b1;
            end
        endcase

        if (idle_s) begin
            ptr_nxt  = {AW{1'b0}};
            cnt_nxt  = {DLY_W{1'b0}};
            key_nxt  = {NUM_KEYS{KEY_IDLE_BIT}};
            sw_nxt   = {SW_W{1'b0}};
            last_nxt = 1'b0;
        end else if (load_s) begin
            ptr_nxt  = rd_addr_s;
            cnt_nxt  = ld_cnt_s;
            key_nxt  = rd_data_s[KEY_LSB +: NUM_KEYS];
            sw_nxt   = rd_data_s[SW_LSB +: SW_W];
            last_nxt = rd_data_s[LAST_B];
        end else begin
            ptr_nxt  = ptr_r;
            key_nxt  = key_r;
            sw_nxt   = sw_r;
            last_nxt = last_r;
        end

        busy_nxt = (state_nxt == ST_PLAY);
        done_nxt = (state_nxt == ST_DONE);
    end

    // State, datapath and registered outputs
    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            state_r  <= ST_IDLE;
            ptr_r    <= {AW{1'b0}};
            cnt_r    <= {DLY_W{1'b0}};
            key_r    <= {NUM_KEYS{KEY_IDLE_BIT}};
            sw_r     <= {SW_W{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            last_r   <= 1'b0;
            wr_err_r <= 1'b0;
        end else begin
            state_r  <= state_nxt;
            ptr_r    <= ptr_nxt;
            cnt_r    <= cnt_nxt;
            key_r    <= key_nxt;
            sw_r     <= sw_nxt;
            busy_r   <= busy_nxt;
            done_r   <= done_nxt;
            last_r   <= last_nxt;
            wr_err_r <= wr_en & (state_r == ST_PLAY);
        end
    end

    assign KEY_out = key_r;
    assign SW_out  = sw_r;
    assign busy    = busy_r;
    assign done    = done_r;
    assign wr_err  = wr_err_r;

`ifdef STIM_SEQ_TRACE_EN
    logic [15:0] applied_r;

    // Applied-step counter; an accepted start restarts the count at step 0
    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            applied_r <= 16'd0;
        end else if (load_s && (state_r != ST_PLAY)) begin
            applied_r <= 16'd1;
        end else if (load_s && (applied_r != 16'hFFFF)) begin
            applied_r <= applied_r + 16'd1;
        end else begin
            applied_r <= applied_r;
        end
    end

    assign step_idx      = ptr_r;
    assign steps_applied = applied_r;
`endif

endmodule
